// File: rtl/dds_lut_loader_if.sv
// Sample stream feeding the DDS LUT loader: valid/ready handshake carrying one
// signed 16-bit sample per beat, with s_last marking the end of a table.
interface dds_lut_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/dds_lut_loader.sv
// Streams 2^AddrWidth samples into the DDS LUT and then arms the DDS (en, then DataPathSelect).
// One word per SetupCycles+3 cycles; s_ready is high only while waiting for the next sample.
module dds_lut_loader #(
    parameter int AddrWidth   = 16,
    parameter int SetupCycles = 1
) (
    input  logic                AXI_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    dds_lut_loader_if.slave     s_if,
    output logic [31:0]         LUTAddress,
    output logic [31:0]         LUTData,
    output logic                LUTWriteEn,
    output logic                en,
    output logic                DataPathSelect,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_SETUP, ST_WRITE, ST_HOLD, ST_ARM_EN, ST_ARM_SEL, ST_DONE
    } state_t;

    localparam logic [AddrWidth-1:0] ADDR_MAX   = {AddrWidth{1'b1}};
    localparam logic [3:0]           SETUP_LOAD = 4'(SetupCycles - 1);

    state_t                 r_state;
    logic [AddrWidth-1:0]   r_cnt;
    logic [AddrWidth-1:0]   r_lut_addr;
    logic [15:0]            r_lut_data;
    logic [3:0]             r_setup_cnt;
    logic                   r_last;
    logic                   r_s_ready;
    logic                   r_we;
    logic                   r_en;
    logic                   r_dps;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   w_accept;

    assign w_accept       = s_if.s_valid & r_s_ready;
    assign s_if.s_ready   = r_s_ready;
    assign LUTAddress     = 32'(r_lut_addr);
    assign LUTData        = {16'h0000, r_lut_data};
    assign LUTWriteEn     = r_we;
    assign en             = r_en;
    assign DataPathSelect = r_dps;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;

    always_ff @(posedge AXI_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lut_addr  <= '0;
            r_lut_data  <= '0;
            r_setup_cnt <= '0;
            r_last      <= 1'b0;
            r_s_ready   <= 1'b0;
            r_we        <= 1'b0;
            r_en        <= 1'b0;
            r_dps       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else if (abort) begin
            // Leaving SETUP here means the pending word is never strobed.
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_we      <= 1'b0;
            r_en      <= 1'b0;
            r_dps     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_error   <= 1'b0;
                        r_done    <= 1'b0;
                        r_en      <= 1'b0;
                        r_dps     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_lut_addr  <= r_cnt;
                        r_lut_data  <= s_if.s_data;
                        r_last      <= s_if.s_last;
                        r_s_ready   <= 1'b0;
                        r_setup_cnt <= SETUP_LOAD;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_setup_cnt == 4'd0) begin
                        r_we    <= 1'b1;
                        r_state <= ST_WRITE;
                    end else begin
                        r_setup_cnt <= r_setup_cnt - 4'd1;
                    end
                end
                ST_WRITE: begin
                    r_we    <= 1'b0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Length check happens before any increment, so the counter cannot wrap.
                    if (r_cnt == ADDR_MAX && r_last) begin
                        r_state <= ST_ARM_EN;
                    end else if (r_cnt == ADDR_MAX || r_last) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_ARM_EN: begin
                    r_en    <= 1'b1;
                    r_state <= ST_ARM_SEL;
                end
                ST_ARM_SEL: begin
                    r_dps   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_lut_loader.sv
// Directed bench for dds_lut_loader with AddrWidth=4, SetupCycles=1 (16-word tables, 4-cycle strobes).
module tb_dds_lut_loader;

    logic        AXI_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [31:0] LUTAddress, LUTData;
    logic        LUTWriteEn, en, DataPathSelect, busy, done, error;

    dds_lut_loader_if bus ();

    dds_lut_loader #(.AddrWidth(4), .SetupCycles(1)) dut (
        .AXI_clk        (AXI_clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .s_if           (bus),
        .LUTAddress     (LUTAddress),
        .LUTData        (LUTData),
        .LUTWriteEn     (LUTWriteEn),
        .en             (en),
        .DataPathSelect (DataPathSelect),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 AXI_clk = ~AXI_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } strobe_t;

    typedef struct {
        int last_idx;
        int gap_a;
        int gap_b;
        int mid_start;
        bit chk_spacing;
        int exp_strobes;
        bit exp_err;
        bit exp_done;
    } vec_t;

    strobe_t strobes[$];
    int      cyc = 0;
    int      en_rise = -1;
    int      dps_rise = -1;
    bit      en_q = 1'b0;
    bit      dps_q = 1'b0;
    int      ready_hold = 0;
    int      ready_viol = 0;
    int      n_cmp = 0;
    int      n_bad = 0;

    always @(posedge AXI_clk) cyc++;

    // Observation at the falling edge, where all DUT outputs are stable.
    always @(negedge AXI_clk) begin
        if (LUTWriteEn) strobes.push_back('{LUTAddress, LUTData, cyc});
        if (en && !en_q) en_rise = cyc;
        if (DataPathSelect && !dps_q) dps_rise = cyc;
        en_q  = en;
        dps_q = DataPathSelect;
        if (ready_hold > 0) begin
            if (bus.s_ready) ready_viol++;
            ready_hold--;
        end
        if (bus.s_ready && bus.s_valid) ready_hold = 3;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_word(input int idx, input bit last);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h1000 + 16'(idx);
        bus.s_last  = last;
        for (int c = 0; c < 40; c++) begin
            @(negedge AXI_clk);
            if (bus.s_ready) begin
                @(posedge AXI_clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        bus.s_last = 1'b0;
        if (!ok) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge AXI_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input int id);
        int n_words;
        int bad_data = 0;
        int bad_gap  = 0;
        strobes.delete();
        en_rise  = -1;
        dps_rise = -1;
        pulse_start();
        chk($sformatf("v%0d_start_busy", id), 64'(busy), 64'd1);
        chk($sformatf("v%0d_start_clear", id), 64'({error, done, en, DataPathSelect}), 64'd0);
        n_words = (v.last_idx < 16) ? v.last_idx + 1 : 16;
        for (int w = 0; w < n_words; w++) begin
            if (w == v.gap_a || w == v.gap_b) begin
                bus.s_valid = 1'b0;
                repeat (3) @(posedge AXI_clk);
                #1;
            end
            if (w == v.mid_start) begin
                bus.s_valid = 1'b0;
                pulse_start();
            end
            send_word(w, w == v.last_idx);
        end
        bus.s_valid = 1'b0;
        repeat (12) @(posedge AXI_clk);
        #1;
        chk($sformatf("v%0d_strobe_count", id), 64'(strobes.size()), 64'(v.exp_strobes));
        foreach (strobes[i]) begin
            if (strobes[i].addr !== 32'(i) || strobes[i].data !== 32'h1000 + 32'(i)) bad_data++;
            if (i > 0 && strobes[i].cyc - strobes[i-1].cyc != 4) bad_gap++;
        end
        chk($sformatf("v%0d_addr_data", id), 64'(bad_data), 64'd0);
        if (v.chk_spacing) chk($sformatf("v%0d_spacing", id), 64'(bad_gap), 64'd0);
        chk($sformatf("v%0d_error", id), 64'(error), 64'(v.exp_err));
        chk($sformatf("v%0d_done", id), 64'(done), 64'(v.exp_done));
        chk($sformatf("v%0d_en_dps", id), 64'({en, DataPathSelect}), v.exp_done ? 64'd3 : 64'd0);
        chk($sformatf("v%0d_busy", id), 64'(busy), 64'd0);
        if (v.exp_done && strobes.size() > 0) begin
            chk($sformatf("v%0d_en_rise", id), 64'(en_rise), 64'(strobes[$].cyc + 3));
            chk($sformatf("v%0d_dps_rise", id), 64'(dps_rise), 64'(strobes[$].cyc + 4));
        end else begin
            chk($sformatf("v%0d_no_en", id), 64'(en_rise), 64'(-1));
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{15, -1, -1, -1, 1'b1, 16, 1'b0, 1'b1};
        vecs[1] = '{15,  2,  9, -1, 1'b0, 16, 1'b0, 1'b1};
        vecs[2] = '{ 5, -1, -1, -1, 1'b1,  6, 1'b1, 1'b0};
        vecs[3] = '{20, -1, -1, -1, 1'b1, 16, 1'b1, 1'b0};
        vecs[4] = '{15, -1, -1,  3, 1'b0, 16, 1'b0, 1'b1};

        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge AXI_clk);
        #1;
        chk("reset_outputs", 64'({LUTWriteEn, en, DataPathSelect, busy, done, error, bus.s_ready}), 64'd0);
        chk("reset_addr_data", {LUTAddress, LUTData}, 64'd0);
        @(negedge AXI_clk);
        rst_n = 1'b1;
        @(posedge AXI_clk);
        #1;

        for (int i = 0; i < 5; i++) run_load(vecs[i], i);

        // Abort while word 7 sits in SETUP.
        strobes.delete();
        pulse_start();
        for (int w = 0; w < 8; w++) send_word(w, 1'b0);
        abort = 1'b1;
        @(posedge AXI_clk);
        #1;
        abort = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_cleared", 64'({LUTWriteEn, en, DataPathSelect, busy, done, bus.s_ready}), 64'd0);
        repeat (5) @(posedge AXI_clk);
        #1;
        chk("abort_strobes", 64'(strobes.size()), 64'd7);
        chk("abort_last_addr", 64'(strobes[$].addr), 64'd6);
        chk("abort_error_kept", 64'(error), 64'd0);

        // Start and abort together: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge AXI_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge AXI_clk);
        #1;
        chk("start_abort_idle", 64'({busy, bus.s_ready}), 64'd0);

        // Asynchronous reset between clock edges mid-load.
        pulse_start();
        for (int w = 0; w < 4; w++) send_word(w, 1'b0);
        chk("pre_reset_addr", 64'(LUTAddress), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({LUTWriteEn, en, DataPathSelect, busy, done, error, bus.s_ready}), 64'd0);
        chk("async_reset_addr_data", {LUTAddress, LUTData}, 64'd0);
        strobes.delete();
        @(negedge AXI_clk);
        rst_n = 1'b1;
        bus.s_valid = 1'b1;
        repeat (10) @(posedge AXI_clk);
        #1;
        bus.s_valid = 1'b0;
        chk("post_reset_no_strobe", 64'(strobes.size()), 64'd0);
        chk("post_reset_idle", 64'({busy, bus.s_ready}), 64'd0);

        chk("s_ready_low_after_accept", 64'(ready_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule
